// File: rtl/pos_cell_reader_pkg.sv
// Shared definitions for the position cell reader.
//   - Memory word geometry: one 96-bit word holds {posz, posy, posx}, 32 b each.
//   - Location of the particle-count field inside the word at address 0.
//   - FSM state encodings, kept as plain logic constants so legacy code can
//     compare against them directly.
package pos_cell_reader_pkg;

  localparam int POS_DATA_WIDTH = 96;
  localparam int AXIS_WIDTH     = 32;

  // The particle count lives in the low bits of the word at address 0.
  localparam int COUNT_LSB = 0;

  // Memory word layout, posx in the least significant lane.
  typedef struct packed {
    logic [AXIS_WIDTH-1:0] posz;
    logic [AXIS_WIDTH-1:0] posy;
    logic [AXIS_WIDTH-1:0] posx;
  } pos_word_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_CNT   = 3'd1;
  localparam logic [2:0] ST_WAIT_CNT = 3'd2;
  localparam logic [2:0] ST_STREAM   = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

endpackage

// File: rtl/pos_stream_fifo.sv
// Synchronous FIFO used as the output buffer of the cell reader.
// The head entry is presented straight from the storage registers, so the
// consumer sees stable data for as long as it stalls.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (empties the FIFO)
//   push         write push_data this cycle (ignored when full and not popping)
//   push_data    entry to write
//   pop          consume the head entry (ignored when empty)
//   head_data    current head entry, meaningful only while head_valid
//   head_valid   FIFO not empty
//   occupancy    number of stored entries, 0..DEPTH
module pos_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_valid = (occupancy != '0);
  assign head_data  = storage[rd_ptr];
  assign do_pop     = pop && head_valid;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push    = push && ((occupancy != OCC_W'(DEPTH)) || do_pop);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers/occupancy, and the top masks the head while it is not valid.
  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pos_cell_reader.sv
// Read-side controller for one position cell memory.
// On an accepted start it reads the particle count at address 0, then reads
// particles 1..N and streams them as {posz,posy,posx} words with their
// address (pid) and a last tag over a valid/ready interface. Reads are only
// issued while the output FIFO is guaranteed to have room for them, so
// back-pressure stalls the memory side and nothing is ever dropped.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           begin a cell read; ignored unless idle
//   busy            high from the cycle after an accepted start until done
//   done            one-cycle pulse after the last beat (or an empty cell)
//   count_err       sticky: stored count was above PARTICLE_NUM-1
//   particle_count  captured (clamped) particle count
//   mem_address     RAM address, holds its last value between reads
//   mem_rden        RAM read enable, high only on issue cycles
//   mem_q           RAM read data, valid RD_LATENCY cycles after issue
//   out_valid/out_ready/out_data/out_pid/out_last   particle stream
module pos_cell_reader
  import pos_cell_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = POS_DATA_WIDTH,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int OCC_W   = $clog2(FIFO_DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM-1);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] next_idx;   // next particle address to issue
  logic [ADDR_WIDTH-1:0] addr_q;     // last issued address

  // In-flight reads, stage RD_LATENCY-1 lines up with valid mem_q.
  // pid 0 marks the count read, which never enters the FIFO.
  logic [RD_LATENCY-1:0] sr_valid;
  logic [RD_LATENCY-1:0] sr_last;
  logic [ADDR_WIDTH-1:0] sr_pid [RD_LATENCY];

  logic                  ret_valid;
  logic [ADDR_WIDTH-1:0] ret_pid;
  logic                  ret_last;
  logic [ADDR_WIDTH-1:0] n_raw;
  logic [OCC_W-1:0]      in_flight;
  logic [OCC_W-1:0]      occupancy;
  logic [OCC_W:0]        credit_sum;
  logic                  credit_ok;
  logic                  issue;
  logic                  issue_last;
  logic                  handshake;

  logic                  push;
  logic [ENTRY_W-1:0]    push_data;
  logic [ENTRY_W-1:0]    head_data;
  logic                  head_valid;

  assign ret_valid = sr_valid[RD_LATENCY-1];
  assign ret_pid   = sr_pid[RD_LATENCY-1];
  assign ret_last  = sr_last[RD_LATENCY-1];
  assign n_raw     = mem_q[COUNT_LSB +: ADDR_WIDTH];

  // Particle reads still on their way from the RAM.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      if (sr_valid[i] && (sr_pid[i] != '0)) in_flight = in_flight + OCC_W'(1);
    end
  end

  // A read may issue only if every read already owed a FIFO slot, plus this
  // one, still fits. Pops in the same cycle are not credited, which keeps the
  // check conservative and still sustains one read per cycle at depth 4.
  assign credit_sum = {1'b0, in_flight} + {1'b0, occupancy};
  assign credit_ok  = credit_sum < (OCC_W+1)'(FIFO_DEPTH);
  assign issue      = (state == ST_STREAM) && credit_ok;
  assign issue_last = issue && (next_idx == particle_count);

  assign mem_rden    = (state == ST_RD_CNT) || issue;
  assign mem_address = (state == ST_RD_CNT) ? '0 :
                       issue                ? next_idx : addr_q;

  assign handshake = out_valid && out_ready;

  assign busy = (state == ST_RD_CNT) || (state == ST_WAIT_CNT) ||
                (state == ST_STREAM) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_RD_CNT;
      ST_RD_CNT:   state_nxt = ST_WAIT_CNT;
      ST_WAIT_CNT: if (ret_valid) state_nxt = (n_raw == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM:   if (issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (handshake && out_last) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      next_idx       <= '0;
      addr_q         <= '0;
      particle_count <= '0;
      count_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_rden) addr_q <= mem_address;
      if ((state == ST_IDLE) && start) count_err <= 1'b0;
      if ((state == ST_WAIT_CNT) && ret_valid) begin
        next_idx <= ADDR_WIDTH'(1);
        if (n_raw > MAX_COUNT) begin
          particle_count <= MAX_COUNT;
          count_err      <= 1'b1;
        end else begin
          particle_count <= n_raw;
        end
      end else if (issue) begin
        next_idx <= next_idx + ADDR_WIDTH'(1);
      end
    end
  end

  // Read-latency tracker; reset discards anything still in the RAM pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_valid <= '0;
      sr_last  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) sr_pid[i] <= '0;
    end else begin
      sr_valid[0] <= mem_rden;
      sr_last[0]  <= issue_last;
      sr_pid[0]   <= mem_address;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_last[i]  <= sr_last[i-1];
        sr_pid[i]   <= sr_pid[i-1];
      end
    end
  end

  assign push      = ret_valid && (ret_pid != '0);
  assign push_data = {ret_last, ret_pid, mem_q};

  pos_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (push_data),
    .pop        (handshake),
    .head_data  (head_data),
    .head_valid (head_valid),
    .occupancy  (occupancy)
  );

  // Outputs read as zero whenever nothing valid is at the head.
  assign out_valid = head_valid;
  assign out_data  = head_valid ? head_data[DATA_WIDTH-1:0] : '0;
  assign out_pid   = head_valid ? head_data[DATA_WIDTH +: ADDR_WIDTH] : '0;
  assign out_last  = head_valid && head_data[ENTRY_W-1];

endmodule
